// File: rtl/huff_table_builder_if.sv
// Code-length buffer read port and code table write port of the canonical Huffman builder.
interface huff_table_builder_if;
  logic [8:0]  buff_raddr;
  logic        buff_ren;
  logic [4:0]  buff_rdata;
  logic [8:0]  code_waddr;
  logic [18:0] code_wdata;
  logic        code_winc;

  modport master (
    output buff_raddr,
    output buff_ren,
    input  buff_rdata,
    output code_waddr,
    output code_wdata,
    output code_winc
  );

  modport slave (
    input  buff_raddr,
    input  buff_ren,
    output buff_rdata,
    input  code_waddr,
    input  code_wdata,
    input  code_winc
  );
endinterface

// File: rtl/huff_table_builder.sv
// Canonical Huffman code generator: counts code lengths, derives next_code[] with a Kraft
// check, then writes one {len, code} entry per symbol into the code table.
module huff_table_builder #(
  parameter int unsigned NumSym = 45
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  huff_table_builder_if.master        bus,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o
);

  localparam logic [8:0] LastSym = 9'(NumSym);

  typedef enum logic [2:0] {StIdle, StCount, StNext, StAssign, StDone} state_e;

  state_e             state_q, state_d;
  logic [8:0]         cnt_q, cnt_d;
  logic               rd_valid_q;
  logic               bad_q, bad_d;
  logic [8:0]         bl_count_q [16];
  logic [8:0]         bl_count_d [16];
  logic [14:0]        next_code_q [16];
  logic [14:0]        next_code_d [16];
  logic signed [16:0] left_q, left_d, left_calc;

  logic [8:0]  buff_raddr;
  logic        buff_ren;
  logic [8:0]  code_waddr;
  logic [18:0] code_wdata;
  logic        code_winc;
  logic [4:0]  len;
  logic [3:0]  len_idx;
  logic [3:0]  idx;
  logic [3:0]  prev_idx;
  logic [8:0]  bl_prev;

  assign len      = bus.buff_rdata;
  assign len_idx  = len[3:0];
  assign idx      = cnt_q[3:0];
  assign prev_idx = idx - 4'd1;
  // bl_count[0] never contributes to next_code[1]
  assign bl_prev  = (prev_idx == 4'd0) ? 9'd0 : bl_count_q[prev_idx];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bad_d       = bad_q;
    bl_count_d  = bl_count_q;
    next_code_d = next_code_q;
    left_d      = left_q;
    left_calc   = (left_q <<< 1) - $signed({8'd0, bl_count_q[idx]});
    buff_ren    = 1'b0;
    buff_raddr  = 9'd0;
    code_winc   = 1'b0;
    code_waddr  = 9'd0;
    code_wdata  = 19'd0;
    done_o      = 1'b0;
    err_o       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StCount;
          cnt_d   = 9'd0;
          for (int i = 0; i < 16; i++) begin
            bl_count_d[i] = 9'd0;
          end
        end
      end

      StCount: begin
        if (cnt_q < LastSym) begin
          buff_ren   = 1'b1;
          buff_raddr = cnt_q;
        end
        if (rd_valid_q) begin
          if (len[4]) begin
            bad_d = 1'b1;
          end else if (len_idx != 4'd0) begin
            bl_count_d[len_idx] = bl_count_q[len_idx] + 9'd1;
          end
        end
        if (cnt_q == LastSym) begin
          state_d = StNext;
          cnt_d   = 9'd1;
          left_d  = 17'sd1;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end

      StNext: begin
        next_code_d[idx] = (next_code_q[prev_idx] + {6'd0, bl_prev}) << 1;
        left_d = left_calc;
        if (left_calc < 0) begin
          bad_d = 1'b1;
        end
        if (idx == 4'd15) begin
          cnt_d   = 9'd0;
          state_d = (bad_q || (left_calc < 0)) ? StDone : StAssign;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end

      StAssign: begin
        if (cnt_q < LastSym) begin
          buff_ren   = 1'b1;
          buff_raddr = cnt_q;
        end
        if (rd_valid_q) begin
          code_winc  = 1'b1;
          code_waddr = cnt_q - 9'd1;
          if (len_idx != 4'd0) begin
            code_wdata           = {len_idx, next_code_q[len_idx]};
            next_code_d[len_idx] = next_code_q[len_idx] + 15'd1;
          end
        end
        if (cnt_q == LastSym) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end

      StDone: begin
        done_o  = 1'b1;
        err_o   = bad_q;
        bad_d   = 1'b0;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  assign busy_o         = (state_q != StIdle);
  assign bus.buff_ren   = buff_ren;
  assign bus.buff_raddr = buff_raddr;
  assign bus.code_winc  = code_winc;
  assign bus.code_waddr = code_waddr;
  assign bus.code_wdata = code_wdata;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= 9'd0;
      rd_valid_q <= 1'b0;
      bad_q      <= 1'b0;
      left_q     <= 17'sd0;
      for (int i = 0; i < 16; i++) begin
        bl_count_q[i]  <= 9'd0;
        next_code_q[i] <= 15'd0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_valid_q  <= buff_ren;
      bad_q       <= bad_d;
      left_q      <= left_d;
      bl_count_q  <= bl_count_d;
      next_code_q <= next_code_d;
    end
  end

endmodule

// File: tb/tb_huff_table_builder.sv
// Directed bench for huff_table_builder with a synchronous-read length buffer model.
module tb_huff_table_builder;
  localparam int N = 45;

  logic clk_i   = 1'b0;
  logic rst_ni  = 1'b0;
  logic start_i = 1'b0;
  logic busy_o, done_o, err_o;

  huff_table_builder_if bus ();

  huff_table_builder #(.NumSym(N)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (start_i),
    .bus     (bus),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .err_o   (err_o)
  );

  always #5 clk_i = ~clk_i;

  logic [4:0] lens [512];
  always @(posedge clk_i) if (bus.buff_ren) bus.buff_rdata <= lens[bus.buff_raddr];

  int vec  = 0;
  int miss = 0;

  int done_cyc, done_cnt, winc_cnt, busy_hi, busy_after, err_val, abort_zero;
  logic [18:0] tbl     [N];
  int          wr_cyc  [N];
  logic [18:0] exp_tbl [N];

  function automatic logic [41:0] outs();
    return {busy_o, done_o, err_o, bus.buff_ren, bus.code_winc, bus.buff_raddr,
            bus.code_waddr, bus.code_wdata};
  endfunction

  task automatic clear_lens();
    for (int i = 0; i < 512; i++) lens[i] = 5'd0;
    for (int i = 0; i < N; i++) exp_tbl[i] = 19'd0;
  endtask

  task automatic load_rfc();
    clear_lens();
    for (int i = 0; i < 5; i++) begin
      lens[i]    = 5'd3;
      exp_tbl[i] = {4'd3, 15'(i + 2)};
    end
    lens[5] = 5'd2; exp_tbl[5] = {4'd2, 15'd0};
    lens[6] = 5'd4; exp_tbl[6] = {4'd4, 15'd14};
    lens[7] = 5'd4; exp_tbl[7] = {4'd4, 15'd15};
  endtask

  // Called at a negedge; start is sampled at the next posedge (cycle T), cycles counted from T.
  task automatic run_collect(input int pulse_at, input bit pulse_done, input int abort_at);
    done_cyc = 0; done_cnt = 0; winc_cnt = 0; busy_hi = 0;
    busy_after = -1; err_val = -1; abort_zero = -1;
    for (int k = 0; k < N; k++) begin
      tbl[k]    = 19'h7ffff;
      wr_cyc[k] = -1;
    end
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (done_cyc != 0 && n == done_cyc + 1) begin
        busy_after = int'(busy_o);
        break;
      end
      if (busy_o) busy_hi++;
      if (bus.code_winc) begin
        winc_cnt++;
        if (int'(bus.code_waddr) < N) begin
          tbl[bus.code_waddr]    = bus.code_wdata;
          wr_cyc[bus.code_waddr] = n;
        end
      end
      if (done_o) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = n;
          err_val  = int'(err_o);
        end
      end
      if (n == pulse_at || (pulse_done && done_o)) start_i = 1'b1;
      if (n == abort_at) begin
        rst_ni = 1'b0;
        #1 abort_zero = (outs() == 42'd0) ? 1 : 0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
      end
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_i);
    vec++;
    if (outs() !== 42'd0) begin
      miss++;
      $display("FAIL reset_outputs: got %h, want 0", outs());
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    vec++;
    if (outs() !== 42'd0) begin
      miss++;
      $display("FAIL idle_outputs: got %h, want 0", outs());
    end
  endtask

  task automatic test_rfc();
    load_rfc();
    @(negedge clk_i);
    run_collect(0, 1'b0, 0);
    vec++;
    if (done_cyc !== 108 || err_val !== 0) begin
      miss++;
      $display("FAIL rfc_done: got cyc %0d err %0d, want cyc 108 err 0", done_cyc, err_val);
    end
    vec++;
    if (winc_cnt !== N) begin
      miss++;
      $display("FAIL rfc_writes: got %0d, want %0d", winc_cnt, N);
    end
    vec++;
    if (busy_hi !== 108 || busy_after !== 0) begin
      miss++;
      $display("FAIL rfc_busy: got hi %0d after %0d, want 108 0", busy_hi, busy_after);
    end
    for (int k = 0; k < N; k++) begin
      vec++;
      if (tbl[k] !== exp_tbl[k] || wr_cyc[k] !== N + 18 + k) begin
        miss++;
        $display("FAIL rfc_entry[%0d]: got %h @%0d, want %h @%0d", k, tbl[k], wr_cyc[k],
                 exp_tbl[k], N + 18 + k);
      end
    end
  endtask

  task automatic test_all_zero();
    clear_lens();
    @(negedge clk_i);
    run_collect(0, 1'b0, 0);
    vec++;
    if (done_cyc !== 108 || err_val !== 0 || winc_cnt !== N) begin
      miss++;
      $display("FAIL zero_done: got cyc %0d err %0d writes %0d, want 108 0 %0d",
               done_cyc, err_val, winc_cnt, N);
    end
    for (int k = 0; k < N; k++) begin
      vec++;
      if (tbl[k] !== 19'd0) begin
        miss++;
        $display("FAIL zero_entry[%0d]: got %h, want 0", k, tbl[k]);
      end
    end
  endtask

  task automatic test_flat();
    clear_lens();
    for (int k = 0; k < 32; k++) begin
      lens[k]    = 5'd5;
      exp_tbl[k] = {4'd5, 15'(k)};
    end
    @(negedge clk_i);
    run_collect(0, 1'b0, 0);
    vec++;
    if (done_cyc !== 108 || err_val !== 0) begin
      miss++;
      $display("FAIL flat_done: got cyc %0d err %0d, want 108 0", done_cyc, err_val);
    end
    for (int k = 0; k < N; k++) begin
      vec++;
      if (tbl[k] !== exp_tbl[k]) begin
        miss++;
        $display("FAIL flat_entry[%0d]: got %h, want %h", k, tbl[k], exp_tbl[k]);
      end
    end
  endtask

  task automatic test_invalid();
    clear_lens();
    for (int k = 0; k < 3; k++) lens[k] = 5'd1;
    @(negedge clk_i);
    run_collect(0, 1'b0, 0);
    vec++;
    if (done_cyc !== 62 || err_val !== 1 || winc_cnt !== 0 || busy_after !== 0) begin
      miss++;
      $display("FAIL oversub: got cyc %0d err %0d writes %0d busy_after %0d, want 62 1 0 0",
               done_cyc, err_val, winc_cnt, busy_after);
    end
    clear_lens();
    lens[0] = 5'd16;
    @(negedge clk_i);
    run_collect(0, 1'b0, 0);
    vec++;
    if (done_cyc !== 62 || err_val !== 1 || winc_cnt !== 0) begin
      miss++;
      $display("FAIL len16: got cyc %0d err %0d writes %0d, want 62 1 0",
               done_cyc, err_val, winc_cnt);
    end
  endtask

  task automatic test_back_to_back();
    load_rfc();
    @(negedge clk_i);
    run_collect(20, 1'b1, 0);
    vec++;
    if (done_cyc !== 108 || done_cnt !== 1 || busy_after !== 0) begin
      miss++;
      $display("FAIL busy_ignore: got cyc %0d dones %0d busy_after %0d, want 108 1 0",
               done_cyc, done_cnt, busy_after);
    end
    // Next run's start lands in the cycle right after done
    run_collect(0, 1'b0, 0);
    vec++;
    if (done_cyc !== 108 || err_val !== 0) begin
      miss++;
      $display("FAIL restart_done: got cyc %0d err %0d, want 108 0", done_cyc, err_val);
    end
    for (int k = 0; k < N; k++) begin
      vec++;
      if (tbl[k] !== exp_tbl[k]) begin
        miss++;
        $display("FAIL restart_entry[%0d]: got %h, want %h", k, tbl[k], exp_tbl[k]);
      end
    end
  endtask

  task automatic test_midrun_reset();
    load_rfc();
    @(negedge clk_i);
    run_collect(0, 1'b0, N + 18 + 10);
    vec++;
    if (abort_zero !== 1) begin
      miss++;
      $display("FAIL abort_outputs: got zero=%0d, want 1", abort_zero);
    end
    vec++;
    if (done_cnt !== 0) begin
      miss++;
      $display("FAIL abort_no_done: got %0d dones, want 0", done_cnt);
    end
    @(negedge clk_i);
    run_collect(0, 1'b0, 0);
    vec++;
    if (done_cyc !== 108 || err_val !== 0 || winc_cnt !== N) begin
      miss++;
      $display("FAIL post_reset_done: got cyc %0d err %0d writes %0d, want 108 0 %0d",
               done_cyc, err_val, winc_cnt, N);
    end
    for (int k = 0; k < N; k++) begin
      vec++;
      if (tbl[k] !== exp_tbl[k]) begin
        miss++;
        $display("FAIL post_reset_entry[%0d]: got %h, want %h", k, tbl[k], exp_tbl[k]);
      end
    end
  endtask

  initial begin
    clear_lens();
    test_reset();
    test_rfc();
    test_all_zero();
    test_flat();
    test_invalid();
    test_back_to_back();
    test_midrun_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
